// File: rtl/scan_pkg.sv
// scan_pkg: state encoding and sizing helpers shared by the LED scan select generator
package scan_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;

    function automatic int cnt_w(input int dwell, input int gap);
        int m;
        m = dwell > gap ? dwell : gap;
        return m > 1 ? $clog2(m) : 1;
    endfunction

    function automatic logic sel_off(input int active_low);
        return active_low != 0;
    endfunction
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: index to one-hot decode; indices at or beyond N decode to all zeros
module onehot_dec #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [W-1:0] i,
    output logic [N-1:0] oh
);
    always_comb for (int k = 0; k < N; k++) oh[k] = i == W'(k);
endmodule

// File: rtl/scan_sel_gen.sv
// scan_sel_gen: time-multiplexed one-hot digit/row select with dwell, blanking gap and manual hold
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int CH_NUM = 32,
    parameter int DWELL_CYC = 5000,
    parameter int BLANK_CYC = 50,
    parameter int ACTIVE_LOW = 0,
    localparam int IDX_W = $clog2(CH_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [IDX_W-1:0]  man_idx,
    output logic [CH_NUM-1:0] sel,
    output logic [IDX_W-1:0]  idx,
    output logic              blank,
    output logic              frame_start
);
    localparam int CW = cnt_w(DWELL_CYC, BLANK_CYC);
    localparam logic [CH_NUM-1:0] OFF = {CH_NUM{sel_off(ACTIVE_LOW)}};

    state_t state;
    logic [CW-1:0] cnt;
    logic [IDX_W-1:0] tgt;
    logic [CH_NUM-1:0] tgt_oh;
    logic run_auto, tgt_ok, dwell_done, blank_done, change, enter, to_blank;

    // tgt is the channel that would be shown next; an out-of-range manual pick decodes to nothing
    assign tgt = mode ? man_idx : (state == IDLE || idx == IDX_W'(CH_NUM - 1)) ? '0 : idx + IDX_W'(1);
    assign tgt_ok = |tgt_oh;
    assign dwell_done = cnt == CW'(DWELL_CYC - 1);
    assign blank_done = BLANK_CYC == 0 || cnt == CW'(BLANK_CYC - 1);
    assign change = run_auto ? dwell_done : mode && man_idx != idx;
    assign enter = state == IDLE ? tgt_ok : state == BLANK ? blank_done && tgt_ok :
                   state == SHOW && change && BLANK_CYC == 0 && tgt_ok;
    assign to_blank = state == IDLE ? !tgt_ok : state == SHOW && change && !(BLANK_CYC == 0 && tgt_ok);

    onehot_dec #(.N(CH_NUM)) u_dec (.i(tgt), .oh(tgt_oh));

    // run_auto latches the mode at SHOW entry so an auto dwell finishes before manual takes over
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            run_auto <= 1'b0;
            blank <= 1'b1;
            frame_start <= 1'b0;
            sel <= OFF;
        end else if (enter) begin
            state <= SHOW;
            idx <= tgt;
            cnt <= '0;
            run_auto <= !mode;
            blank <= 1'b0;
            frame_start <= !mode && tgt == '0;
            sel <= tgt_oh ^ OFF;
        end else begin
            frame_start <= 1'b0;
            if (to_blank) begin
                state <= BLANK;
                cnt <= '0;
                blank <= 1'b1;
                sel <= OFF;
            end else if (state == SHOW && !run_auto && !mode)
                run_auto <= 1'b1;
            else if ((state == SHOW && run_auto) || (state == BLANK && !blank_done))
                cnt <= cnt + CW'(1);
        end
    end
endmodule
